// File: rtl/seq_serializer.sv
// seq_serializer
//   Parallel-to-serial front end for the serial pattern detectors. A WIDTH-bit
//   word is accepted over a valid/ready handshake and shifted out one bit per
//   clock on x. Back-to-back words run with no gap. Between words, x holds
//   IDLE_BIT so that idle cycles cannot complete a false match downstream.
//
// Parameters
//   WIDTH     word length in bits (>= 2)
//   MSB_FIRST 1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   IDLE_BIT  level on x while no word is being shifted
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   din        parallel word, sampled only at the accept edge
//   din_valid  din is valid this cycle
//   din_ready  a word is accepted at the next rising edge (combinational)
//   x          serial bit stream
//   x_valid    x carries a data bit this cycle
//   busy       a word is being shifted
//   done       high while the last bit of a word is on x
module seq_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  logic             last;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_sr;
  logic [WIDTH-1:0] shift_sr;

  // Last-bit cycle: decoded from registers only, so done is glitch-free.
  assign last      = (state == SHIFT) && (cnt == LAST);
  assign done      = last;
  assign din_ready = rst && ((state == IDLE) || last);
  assign accept    = din_valid && din_ready;

  // Shift direction. The first bit goes straight to x, the rest wait in sr
  // aligned so that the next bit always sits at the outgoing end.
  if (MSB_FIRST) begin : g_msb
    assign first_bit = din[WIDTH-1];
    assign load_sr   = {din[WIDTH-2:0], 1'b0};
    assign next_bit  = sr[WIDTH-1];
    assign shift_sr  = {sr[WIDTH-2:0], 1'b0};
  end else begin : g_lsb
    assign first_bit = din[0];
    assign load_sr   = {1'b0, din[WIDTH-1:1]};
    assign next_bit  = sr[0];
    assign shift_sr  = {1'b0, sr[WIDTH-1:1]};
  end

  // Control FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            x       <= first_bit;
            sr      <= load_sr;
            cnt     <= '0;
            x_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            x   <= next_bit;
            sr  <= shift_sr;
            cnt <= cnt + CW'(1);
          end else if (accept) begin
            // New word follows the old last bit with no gap.
            x   <= first_bit;
            sr  <= load_sr;
            cnt <= '0;
          end else begin
            state   <= IDLE;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, x, x_valid, busy, done;

  logic [3:0] din4;
  logic       din4_valid;
  logic       din4_ready, x4, x4_valid, busy4, done4;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(din4_valid), .din_ready(din4_ready),
    .x(x4), .x_valid(x4_valid), .busy(busy4), .done(done4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of bits still to appear on x, head = bit on x now.
  bit q[$];
  logic seen_x, seen_ready;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ex, exv, exd, exr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic ex, exv, exd, exr;
    ex  = (q.size() > 0) ? q[0] : 1'b1;
    exv = (q.size() > 0);
    exd = (q.size() == 1);
    exr = rst && (q.size() <= 1);
    chk({tag, ".x"},         32'(x),         32'(ex));
    chk({tag, ".x_valid"},   32'(x_valid),   32'(exv));
    chk({tag, ".busy"},      32'(busy),      32'(exv));
    chk({tag, ".done"},      32'(done),      32'(exd));
    chk({tag, ".din_ready"}, 32'(din_ready), 32'(exr));
  endtask

  // Called at a falling edge; applies inputs for one cycle and advances the model.
  task automatic step(input string tag, input logic v, input logic [7:0] d);
    bit acc;
    din_valid = v;
    din       = d;
    #1;
    model_check(tag);
    seen_x     = x;
    seen_ready = din_ready;
    acc = v && rst && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq16;
    logic [16:0] rdy_mask;
    logic [7:0]  seq8;
    logic [3:0]  s4;
    logic [3:0]  hist;
    logic [8:0]  zmask;
    int          pos;

    rst = 1'b0; din = '0; din_valid = 1'b0; din4 = '0; din4_valid = 1'b0;
    @(negedge clk);

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) step("reset", 1'($urandom), 8'($urandom));
    rst = 1'b1;
    #1 chk("ready_after_release", 32'(din_ready), 32'd1);
    chk("ready4_after_release", 32'(din4_ready), 32'd1);
    @(negedge clk);

    // Single word 8'h66, table driven: entry i = inputs and outputs of cycle i.
    tbl[0] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] w;
      w = 8'h66;
      tbl[i] = '{1'b0, 8'h00, w[8-i], 1'b1, (i == 8), (i == 8)};
    end
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    hist = '0; zmask = '0; pos = 0;
    for (int i = 0; i < 10; i++) begin
      din_valid = tbl[i].v;
      din       = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d.x", i),         32'(x),         32'(tbl[i].ex));
      chk($sformatf("tbl%0d.x_valid", i),   32'(x_valid),   32'(tbl[i].exv));
      chk($sformatf("tbl%0d.done", i),      32'(done),      32'(tbl[i].exd));
      chk($sformatf("tbl%0d.din_ready", i), 32'(din_ready), 32'(tbl[i].exr));
      if (x_valid) begin
        pos++;
        hist = {hist[2:0], x};
        if (pos >= 4 && hist == 4'b0110 && pos < 9) zmask[pos] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("detector_0110_hits", 32'(zmask), 32'h110);

    // Back-to-back A5 then 3C with din_valid held high.
    seq16 = '0; rdy_mask = '0;
    for (int c = 0; c <= 16; c++) begin
      if (c == 16)     step("b2b", 1'b0, 8'h00);
      else if (c < 8)  step("b2b", 1'b1, 8'hA5);
      else             step("b2b", 1'b1, 8'h3C);
      rdy_mask[c] = seen_ready;
      if (c >= 1) seq16 = {seq16[14:0], seen_x};
    end
    chk("b2b_stream", 32'(seq16), 32'hA53C);
    chk("b2b_ready_pulses", 32'(rdy_mask), 32'h10101);

    // Hold-off: FF offered during every cycle of an 00 word.
    seq16 = '0;
    step("hold", 1'b1, 8'h00);
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) step("hold", 1'b0, 8'h00);
      else         step("hold", 1'b1, 8'hFF);
      seq16 = {seq16[14:0], seen_x};
    end
    chk("holdoff_stream", 32'(seq16), 32'h00FF);
    step("hold_idle", 1'b0, 8'h00);

    // Mid-word reset after three bits of F0.
    step("mid", 1'b1, 8'hF0);
    for (int c = 0; c < 3; c++) step("mid", 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("midrst.x", 32'(x), 32'd1);
    chk("midrst.x_valid", 32'(x_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.din_ready", 32'(din_ready), 32'd0);
    q.delete();
    @(negedge clk);
    for (int c = 0; c < 3; c++) step("midrst_hold", 1'b1, 8'hFF);
    rst = 1'b1;
    #1 chk("midrst.ready_release", 32'(din_ready), 32'd1);
    seq8 = '0;
    step("after", 1'b1, 8'h0F);
    for (int c = 0; c < 8; c++) begin
      step("after", 1'b0, 8'h00);
      seq8 = {seq8[6:0], seen_x};
    end
    chk("after_reset_stream", 32'(seq8), 32'h0F);
    step("after_idle", 1'b0, 8'h00);

    // LSB-first, WIDTH=4.
    for (int t = 0; t < 2; t++) begin
      logic [3:0] w, expseq;
      w      = (t == 0) ? 4'b0110 : 4'b0011;
      expseq = (t == 0) ? 4'b0110 : 4'b1100;
      din4 = w; din4_valid = 1'b1;
      #1 chk($sformatf("lsb%0d.ready", t), 32'(din4_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      din4_valid = 1'b0; din4 = 4'hF;
      s4 = '0;
      for (int c = 0; c < 4; c++) begin
        #1;
        chk($sformatf("lsb%0d.x_valid%0d", t, c), 32'(x4_valid), 32'd1);
        chk($sformatf("lsb%0d.done%0d", t, c), 32'(done4), 32'(c == 3));
        s4 = {s4[2:0], x4};
        @(posedge clk); @(negedge clk);
      end
      chk($sformatf("lsb%0d.stream", t), 32'(s4), 32'(expseq));
      #1;
      chk($sformatf("lsb%0d.idle_x", t), 32'(x4), 32'd1);
      chk($sformatf("lsb%0d.idle_valid", t), 32'(x4_valid), 32'd0);
      @(negedge clk);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) step("rand", 1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < 10; i++) step("drain", 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
